// File: rtl/bcd_lcd_scheduler.sv
// Round-robin scheduler sharing one binary-to-BCD converter between two requesters and writing 3 ASCII chars per grant.
// Optional macro BLANK_LEADING_ZERO_EN replaces leading zero digits with spaces.
module bcd_lcd_scheduler #(
  parameter logic [6:0] ROW0_ADDR = 7'h00,
  parameter logic [6:0] ROW1_ADDR = 7'h40
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [7:0] val0,
  input  logic       req1,
  input  logic [7:0] val1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [7:0] bin,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [1:0] hundreds,
  output logic       wr_req,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic       wr_ack,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, CONV, WR_H, WR_T, WR_O} state_t;

  state_t     state;
  logic       last;
  logic [1:0] h_dig;
  logic [3:0] t_dig;
  logic [3:0] o_dig;
  logic [6:0] base;
  logic [7:0] h_char;
  logic [7:0] t_char;
  logic [7:0] o_char;

  always_comb begin
    h_char = 8'h30 + {6'd0, h_dig};
    t_char = 8'h30 + {4'd0, t_dig};
    o_char = 8'h30 + {4'd0, o_dig};
`ifdef BLANK_LEADING_ZERO_EN
    if (h_dig == 2'd0) begin
      h_char = 8'h20;
      if (t_dig == 4'd0) t_char = 8'h20;
    end
`else
`endif
  end

  // WR_H spends its first cycle raising wr_req; later acks advance one character per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= 1'b1;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      bin     <= 8'h00;
      wr_req  <= 1'b0;
      wr_addr <= 7'h00;
      wr_data <= 8'h00;
      busy    <= 1'b0;
      h_dig   <= 2'd0;
      t_dig   <= 4'd0;
      o_dig   <= 4'd0;
      base    <= 7'h00;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 && (!req1 || last)) begin
            bin   <= val0;
            last  <= 1'b0;
            gnt0  <= 1'b1;
            busy  <= 1'b1;
            state <= CONV;
          end else if (req1) begin
            bin   <= val1;
            last  <= 1'b1;
            gnt1  <= 1'b1;
            busy  <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          h_dig <= hundreds;
          t_dig <= tens;
          o_dig <= ones;
          base  <= last ? ROW1_ADDR : ROW0_ADDR;
          state <= WR_H;
        end
        WR_H: begin
          if (!wr_req) begin
            wr_req  <= 1'b1;
            wr_addr <= base;
            wr_data <= h_char;
          end else if (wr_ack) begin
            wr_addr <= base + 7'd1;
            wr_data <= t_char;
            state   <= WR_T;
          end
        end
        WR_T: begin
          if (wr_ack) begin
            wr_addr <= base + 7'd2;
            wr_data <= o_char;
            state   <= WR_O;
          end
        end
        WR_O: begin
          if (wr_ack) begin
            wr_req <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_lcd_scheduler.sv
// Scoreboard bench for bcd_lcd_scheduler: stimulus pushes expected grants/writes, a negedge monitor pops and compares.
module tb_bcd_lcd_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0;
  logic [7:0] val0 = 8'h00;
  logic       req1 = 1'b0;
  logic [7:0] val1 = 8'h00;
  logic       gnt0;
  logic       gnt1;
  logic [7:0] bin;
  logic [3:0] ones;
  logic [3:0] tens;
  logic [1:0] hundreds;
  logic       wr_req;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack = 1'b1;
  logic       busy;

  int checks = 0;
  int errors = 0;
  bit ack_slow = 1'b0;
  int ack_cnt = 0;

  typedef struct {logic [6:0] addr; logic [7:0] data;} wr_t;
  typedef struct {int id; logic [7:0] val;} gnt_t;
  wr_t  wr_q[$];
  gnt_t gnt_q[$];

  logic       prev_pend = 1'b0;
  logic       prev_gnt = 1'b0;
  logic [6:0] prev_addr = 7'h00;
  logic [7:0] prev_data = 8'h00;

  bcd_lcd_scheduler dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .val0(val0), .req1(req1), .val1(val1),
    .gnt0(gnt0), .gnt1(gnt1), .bin(bin), .ones(ones), .tens(tens), .hundreds(hundreds),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .busy(busy)
  );

  // Combinational converter the DUT time-shares.
  assign hundreds = 2'(bin / 8'd100);
  assign tens     = 4'((bin / 8'd10) % 8'd10);
  assign ones     = 4'(bin % 8'd10);

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pushGrant(input int id, input logic [7:0] v);
    gnt_t g;
    g.id = id;
    g.val = v;
    gnt_q.push_back(g);
  endtask

  task automatic pushWrites(input logic [6:0] b, input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
    wr_t w;
    w.addr = b;      w.data = c0; wr_q.push_back(w);
    w.addr = b + 1;  w.data = c1; wr_q.push_back(w);
    w.addr = b + 2;  w.data = c2; wr_q.push_back(w);
  endtask

  task automatic applyStimulus(input bit r0, input bit r1, input logic [7:0] v0, input logic [7:0] v1, input int ngrants);
    int seen;
    seen = 0;
    @(posedge clk); #1;
    req0 = r0; req1 = r1; val0 = v0; val1 = v1;
    for (int i = 0; i < 200 && seen < ngrants; i++) begin
      @(posedge clk); #1;
      if (gnt0 || gnt1) seen++;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    checkOutput("grant_count", seen, ngrants);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("idle_timeout", {31'd0, busy}, 0);
    repeat (2) @(posedge clk);
  endtask

  // Slow mode holds each character unacknowledged for three cycles.
  always @(posedge clk) begin
    #1;
    if (!ack_slow) wr_ack = 1'b1;
    else if (!wr_req) begin
      wr_ack = 1'b0;
      ack_cnt = 0;
    end else if (ack_cnt == 3) begin
      wr_ack = 1'b1;
      ack_cnt = 0;
    end else begin
      wr_ack = 1'b0;
      ack_cnt++;
    end
  end

  always @(negedge clk) begin : monitor
    gnt_t g;
    wr_t  w;
    if (rst_n) begin
      if (gnt0 || gnt1) begin
        checkOutput("gnt_single_cycle", {31'd0, prev_gnt}, 0);
        checkOutput("gnt_both", {31'd0, gnt0 & gnt1}, 0);
        if (gnt_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_grant: got gnt0=%0b gnt1=%0b expected none", gnt0, gnt1);
        end else begin
          g = gnt_q.pop_front();
          checkOutput("gnt_id", gnt1 ? 1 : 0, g.id);
          checkOutput("bin_at_gnt", {24'd0, bin}, {24'd0, g.val});
        end
      end
      if (prev_pend && wr_req) begin
        checkOutput("addr_stable", {25'd0, wr_addr}, {25'd0, prev_addr});
        checkOutput("data_stable", {24'd0, wr_data}, {24'd0, prev_data});
      end
      if (wr_req && wr_ack) begin
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_write: got addr %0h data %0h expected none", wr_addr, wr_data);
        end else begin
          w = wr_q.pop_front();
          checkOutput("wr_addr", {25'd0, wr_addr}, {25'd0, w.addr});
          checkOutput("wr_data", {24'd0, wr_data}, {24'd0, w.data});
        end
      end
      prev_gnt  = gnt0 | gnt1;
      prev_pend = wr_req & ~wr_ack;
      prev_addr = wr_addr;
      prev_data = wr_data;
    end else begin
      prev_gnt  = 1'b0;
      prev_pend = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 100000ns");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_gnt0", {31'd0, gnt0}, 0);
    checkOutput("rst_gnt1", {31'd0, gnt1}, 0);
    checkOutput("rst_wr_req", {31'd0, wr_req}, 0);
    checkOutput("rst_busy", {31'd0, busy}, 0);
    checkOutput("rst_bin", {24'd0, bin}, 0);
    checkOutput("rst_wr_addr", {25'd0, wr_addr}, 0);
    checkOutput("rst_wr_data", {24'd0, wr_data}, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 255 on requester 0 with exact latency checks.
    pushGrant(0, 8'd255);
    pushWrites(7'h00, 8'h32, 8'h35, 8'h35);
    @(posedge clk); #1;
    req0 = 1'b1; val0 = 8'd255;
    @(posedge clk); #1;
    checkOutput("t1_gnt0", {31'd0, gnt0}, 1);
    checkOutput("t1_busy", {31'd0, busy}, 1);
    req0 = 1'b0;
    @(posedge clk); #1;
    checkOutput("t1_gnt0_drop", {31'd0, gnt0}, 0);
    checkOutput("t1_wr_req_early", {31'd0, wr_req}, 0);
    @(posedge clk); #1;
    checkOutput("t1_wr_req_rise", {31'd0, wr_req}, 1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t1_busy_t4", {31'd0, busy}, 1);
    @(posedge clk); #1;
    checkOutput("t1_busy_t5", {31'd0, busy}, 0);
    checkOutput("t1_wr_req_t5", {31'd0, wr_req}, 0);
    waitIdle();

    // 7 on requester 1.
    pushGrant(1, 8'd7);
`ifdef BLANK_LEADING_ZERO_EN
    pushWrites(7'h40, 8'h20, 8'h20, 8'h37);
`else
    pushWrites(7'h40, 8'h30, 8'h30, 8'h37);
`endif
    applyStimulus(1'b0, 1'b1, 8'd0, 8'd7, 1);
    waitIdle();

    // Both held: grants alternate 0,1,0,1.
    for (int i = 0; i < 2; i++) begin
      pushGrant(0, 8'd100);
      pushWrites(7'h00, 8'h31, 8'h30, 8'h30);
      pushGrant(1, 8'd42);
`ifdef BLANK_LEADING_ZERO_EN
      pushWrites(7'h40, 8'h20, 8'h34, 8'h32);
`else
      pushWrites(7'h40, 8'h30, 8'h34, 8'h32);
`endif
    end
    applyStimulus(1'b1, 1'b1, 8'd100, 8'd42, 4);
    waitIdle();

    // Slow acknowledge, 128.
    ack_slow = 1'b1;
    pushGrant(0, 8'd128);
    pushWrites(7'h00, 8'h31, 8'h32, 8'h38);
    applyStimulus(1'b1, 1'b0, 8'd128, 8'd0, 1);
    waitIdle();
    ack_slow = 1'b0;
    repeat (2) @(posedge clk);

    // Reset during WR_T: only the hundreds character is written.
    pushGrant(0, 8'd155);
    begin
      wr_t w;
      w.addr = 7'h00; w.data = 8'h31;
      wr_q.push_back(w);
    end
    @(posedge clk); #1;
    req0 = 1'b1; val0 = 8'd155;
    @(posedge clk); #1;
    req0 = 1'b0;
    repeat (2) @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_wr_req", {31'd0, wr_req}, 0);
    checkOutput("midrst_busy", {31'd0, busy}, 0);
    checkOutput("midrst_bin", {24'd0, bin}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pushGrant(0, 8'd200);
    pushWrites(7'h00, 8'h32, 8'h30, 8'h30);
    pushGrant(1, 8'd99);
`ifdef BLANK_LEADING_ZERO_EN
    pushWrites(7'h40, 8'h20, 8'h39, 8'h39);
`else
    pushWrites(7'h40, 8'h30, 8'h39, 8'h39);
`endif
    applyStimulus(1'b1, 1'b1, 8'd200, 8'd99, 2);
    waitIdle();

    // REQ1 raised and dropped while busy is never served.
    pushGrant(0, 8'd9);
`ifdef BLANK_LEADING_ZERO_EN
    pushWrites(7'h00, 8'h20, 8'h20, 8'h39);
`else
    pushWrites(7'h00, 8'h30, 8'h30, 8'h39);
`endif
    @(posedge clk); #1;
    req0 = 1'b1; val0 = 8'd9;
    @(posedge clk); #1;
    req0 = 1'b0;
    req1 = 1'b1; val1 = 8'd77;
    repeat (2) @(posedge clk);
    #1;
    req1 = 1'b0;
    waitIdle();
    repeat (4) @(posedge clk);

    checkOutput("grants_left", gnt_q.size(), 0);
    checkOutput("writes_left", wr_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
